id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter REG_AW, 5, register-address width.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  decode stage presents an instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle; low = upstream holds.
REQ-007 flush  in  1  branch-taken kill of the instruction being loaded.
REQ-008 rs_addr, rt_addr, rd_addr  in  REG_AW  source/destination register numbers.
REQ-009 rs_data, rt_data  in  DATA_W  register-file read values.
REQ-010 imm  in  DATA_W  sign-extended immediate.
REQ-011 alu_op  in  2  00 add, 01 sub, 10 R-type via funct, 11 or.
REQ-012 funct  in  6  R-type function field.
REQ-013 alu_src, reg_write, mem_read, mem_write  in  1 each  decode controls.
REQ-014 exmem_reg_write, exmem_rd, exmem_result  in  1/REG_AW/DATA_W  EX/MEM writeback info.
REQ-015 memwb_reg_write, memwb_rd, memwb_result  in  1/REG_AW/DATA_W  MEM/WB writeback info.
REQ-016 out_valid  out  1  ALU inputs below are a live instruction.
REQ-017 ALUControl  out  4  ALU op: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor.
REQ-018 A, B  out  DATA_W  ALU operands.
REQ-019 out_rd, out_reg_write, out_mem_read, out_mem_write  out  REG_AW/1/1/1  forwarded downstream.
REQ-020 out_store_data  out  DATA_W  rt value (forwarded) for sw.

Function
REQ-021 Stage register holds one instruction; two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-022 Load on edge when in_valid & in_ready & !flush -> FULL; otherwise -> EMPTY (bubble).
REQ-023 Latency: one cycle from acceptance to out_valid.
REQ-024 ALUControl decoded at load: alu_op 00->0010, 01->0110, 11->0001; 10 with funct 100000/100001->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111, any other funct->0010.
REQ-025 Load-use hazard: held FULL & out_mem_read & out_rd!=0 & out_rd equals incoming rs_addr or (rt_addr when !alu_src or mem_write) -> in_ready=0 for exactly that cycle, bubble inserted.
REQ-026 in_ready=1 in every other cycle, including EMPTY.
REQ-027 A = forwarded rs value; B = imm when held alu_src=1, else forwarded rt value; combinational from held state and current writeback inputs.
REQ-028 Forward select per operand: exmem match (reg_write, rd!=0, rd==addr) wins over memwb match; else held register-file value.
REQ-029 Register 0 never forwarded, never triggers hazard.
REQ-030 flush has priority over load and over hazard stall; flush with in_valid consumes and drops the instruction (in_ready=1).
REQ-031 out_store_data uses the same rt forwarding as B ignoring alu_src.
REQ-032 When EMPTY, out_reg_write, out_mem_read, out_mem_write = 0; data outputs don't-care.

Reset
REQ-033 Reset dominates flush, stall, load; next state EMPTY.
REQ-034 After reset: out_valid=0, ALUControl=0010, out_rd=0, all control outputs 0, held data 0, in_ready=1.
REQ-035 Reset asserted mid-stall discards the held instruction; no replay.

Configuration
REQ-036 Macro ID_EX_FORWARDING_EN defined: REQ-027/028 forwarding and REQ-025 load-use stall only.
REQ-037 Macro undefined: A/B use held register-file values only; stall while incoming rs/rt (nonzero, used) matches held out_rd (out_reg_write) or exmem_rd (exmem_reg_write); register file write-before-read covers MEM/WB.

Structure
REQ-038 Shared package holds ALUControl code constants, alu_op encodings, funct constants.
REQ-039 Decode in sub-module alu_ctrl_decode (alu_op, funct -> ALUControl); forwarding and hazard logic in-module.

Verification
REQ-040 Reset for 2 cycles with in_valid=1 -> out_valid=0, ALUControl=0010, in_ready=1.
REQ-041 add $3,$1,$2 (rs_data=5, rt_data=7, funct 100000) -> next cycle out_valid=1, A=5, B=7, ALUControl=0010.
REQ-042 Held rs=$4, exmem_rd=4 result 0x10, memwb_rd=4 result 0x20 -> A=0x10; exmem_reg_write=0 -> A=0x20; rs=$0 with exmem_rd=0 -> A=rs_data.
REQ-043 Held lw $5 then incoming sub $6,$5,$1 -> in_ready=0 one cycle, bubble (out_valid=0), sub loads following cycle with ALUControl=0110.
REQ-044 flush=1 with in_valid=1 during hazard -> in_ready=1, next out_valid=0, control outputs 0.
REQ-045 Macro undefined: add $7,$3,$3 behind held $3 writer -> in_ready=0 until neither held nor exmem rd equals 3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
// Shared constants for the ID/EX stage: ALUControl codes, alu_op encodings
// and the R-type funct values the decoder recognises.
// No ports.

package id_ex_stage_pkg;

  // ALUControl codes driven to the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // alu_op encodings from the main decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// alu_ctrl_decode
// Combinational ALUControl decode from the main-decoder alu_op and the
// R-type funct field. Unrecognised funct values fall back to add.
// Ports:
//   alu_op      in  2  main-decoder ALU operation class
//   funct       in  6  R-type function field
//   alu_control out 4  ALU operation code

module alu_ctrl_decode
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  logic [3:0] rtype_ctrl;

  always_comb begin
    rtype_ctrl = ALU_ADD;
    case (funct)
      FUNCT_ADD:  rtype_ctrl = ALU_ADD;
      FUNCT_ADDU: rtype_ctrl = ALU_ADD;
      FUNCT_SUB:  rtype_ctrl = ALU_SUB;
      FUNCT_AND:  rtype_ctrl = ALU_AND;
      FUNCT_OR:   rtype_ctrl = ALU_OR;
      FUNCT_NOR:  rtype_ctrl = ALU_NOR;
      FUNCT_SLT:  rtype_ctrl = ALU_SLT;
      default:    rtype_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_RTYPE: alu_control = rtype_ctrl;
      ALUOP_OR:    alu_control = ALU_OR;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with operand selection and hazard detection.
// Holds one decoded instruction; the ALU operands are built combinationally
// from the held state and the current writeback buses.
//
// Build option: ID_EX_FORWARDING_EN
//   defined   - EX/MEM and MEM/WB results are forwarded into A/B/store data,
//               and only a load-use dependency stalls.
//   undefined - held register-file values are used as-is; any dependency on
//               the held writer or the EX/MEM writer stalls (the register
//               file's write-before-read covers MEM/WB).
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid / in_ready / flush      upstream handshake and branch kill
//   rs_addr, rt_addr, rd_addr        register numbers of the incoming instr
//   rs_data, rt_data, imm            register-file values and immediate
//   alu_op, funct                    ALU operation selection
//   alu_src, reg_write, mem_read,
//   mem_write                        decode controls
//   exmem_*, memwb_*                 downstream writeback info
//   out_valid                        held instruction is live
//   ALUControl, A, B                 ALU control and operands
//   out_rd, out_reg_write,
//   out_mem_read, out_mem_write      controls passed downstream
//   out_store_data                   rt value for stores
//
// state | meaning
// EMPTY | no live instruction held, controls forced low
// FULL  | a live instruction is held and presented to EX

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  output logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_store_data
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [3:0]        alu_ctrl_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [3:0]        alu_ctrl_dec;
  logic              rt_used;
  logic              stall;
  logic              load;
  logic [DATA_W-1:0] opnd_rs;
  logic [DATA_W-1:0] opnd_rt;

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_ctrl_dec)
  );

  // rt is only a true source when it feeds the ALU or is the store value
  assign rt_used = !alu_src || mem_write;

`ifdef ID_EX_FORWARDING_EN
  logic ex_hit_rs, ex_hit_rt, wb_hit_rs, wb_hit_rt;

  assign ex_hit_rs = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr_q);
  assign ex_hit_rt = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_addr_q);
  assign wb_hit_rs = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr_q);
  assign wb_hit_rt = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_addr_q);

  // the younger EX/MEM result takes precedence over MEM/WB
  assign opnd_rs = ex_hit_rs ? exmem_result : (wb_hit_rs ? memwb_result : rs_data_q);
  assign opnd_rt = ex_hit_rt ? exmem_result : (wb_hit_rt ? memwb_result : rt_data_q);

  // a load result cannot be forwarded in time; insert one bubble
  assign stall = in_valid && (state_q == FULL) && mem_read_q && (rd_q != '0) &&
                 ((rd_q == rs_addr) || (rt_used && (rd_q == rt_addr)));
`else
  logic held_hit_rs, held_hit_rt, ex_hit_rs, ex_hit_rt;
  logic unused_fwd;

  assign held_hit_rs = (state_q == FULL) && reg_write_q && (rd_q == rs_addr);
  assign held_hit_rt = (state_q == FULL) && reg_write_q && (rd_q == rt_addr);
  assign ex_hit_rs   = exmem_reg_write && (exmem_rd == rs_addr);
  assign ex_hit_rt   = exmem_reg_write && (exmem_rd == rt_addr);

  assign opnd_rs = rs_data_q;
  assign opnd_rt = rt_data_q;

  assign stall = in_valid &&
                 (((rs_addr != '0) && (held_hit_rs || ex_hit_rs)) ||
                  (rt_used && (rt_addr != '0) && (held_hit_rt || ex_hit_rt)));

  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                        rs_addr_q, rt_addr_q};
`endif

  // flush consumes the incoming instruction even when it would have stalled
  assign in_ready = flush || !stall;
  assign load     = in_valid && !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_ctrl_q  <= ALU_ADD;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (load) begin
      state_q     <= FULL;
      rs_addr_q   <= rs_addr;
      rt_addr_q   <= rt_addr;
      rd_q        <= rd_addr;
      rs_data_q   <= rs_data;
      rt_data_q   <= rt_data;
      imm_q       <= imm;
      alu_ctrl_q  <= alu_ctrl_dec;
      alu_src_q   <= alu_src;
      reg_write_q <= reg_write;
      mem_read_q  <= mem_read;
      mem_write_q <= mem_write;
    end else begin
      // bubble: data fields are left as-is, only side-effecting controls drop
      state_q     <= EMPTY;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end
  end

  assign out_valid      = (state_q == FULL);
  assign ALUControl     = alu_ctrl_q;
  assign A              = opnd_rs;
  assign B              = alu_src_q ? imm_q : opnd_rt;
  assign out_store_data = opnd_rt;
  assign out_rd         = rd_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data, imm;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        alu_src, reg_write, mem_read, mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        out_valid;
  logic [3:0]  alu_control;
  logic [31:0] a_opnd, b_opnd;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_store_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .flush           (flush),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .rd_addr         (rd_addr),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .imm             (imm),
    .alu_op          (alu_op),
    .funct           (funct),
    .alu_src         (alu_src),
    .reg_write       (reg_write),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .out_valid       (out_valid),
    .ALUControl      (alu_control),
    .A               (a_opnd),
    .B               (b_opnd),
    .out_rd          (out_rd),
    .out_reg_write   (out_reg_write),
    .out_mem_read    (out_mem_read),
    .out_mem_write   (out_mem_write),
    .out_store_data  (out_store_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im,
                           input logic [1:0] op, input logic [5:0] fn,
                           input logic src, input logic rw, input logic mr, input logic mw);
    rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; imm = im;
    alu_op = op; funct = fn;
    alu_src = src; reg_write = rw; mem_read = mr; mem_write = mw;
  endtask

  task automatic clear_wb();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
    clear_wb();
    set_instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (alu_control !== 4'b0010) begin tests_failed++; $display("FAIL reset_alucontrol got %b want 0010", alu_control); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++; if (out_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
    tests_run++; if ({out_reg_write, out_mem_read, out_mem_write} !== 3'b000) begin tests_failed++; $display("FAIL reset_ctrl got %b want 000", {out_reg_write, out_mem_read, out_mem_write}); end
    tests_run++; if (a_opnd !== 32'd0 || b_opnd !== 32'd0) begin tests_failed++; $display("FAIL reset_data got A=%h B=%h want 0/0", a_opnd, b_opnd); end
    reset = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_add();
    set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL add_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_out_valid got %b want 1", out_valid); end
    tests_run++; if (a_opnd !== 32'd5) begin tests_failed++; $display("FAIL add_A got %h want 5", a_opnd); end
    tests_run++; if (b_opnd !== 32'd7) begin tests_failed++; $display("FAIL add_B got %h want 7", b_opnd); end
    tests_run++; if (alu_control !== 4'b0010) begin tests_failed++; $display("FAIL add_alucontrol got %b want 0010", alu_control); end
    tests_run++; if (out_rd !== 5'd3 || out_reg_write !== 1'b1) begin tests_failed++; $display("FAIL add_dest got rd=%0d rw=%b want 3/1", out_rd, out_reg_write); end
    tick();
    tests_run++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin tests_failed++; $display("FAIL add_bubble got v=%b rw=%b want 0/0", out_valid, out_reg_write); end
  endtask

  localparam logic [1:0] DEC_OP [12] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10,
                                         2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam logic [5:0] DEC_FN [12] = '{6'b000000, 6'b000000, 6'b000000, 6'b100000,
                                         6'b100001, 6'b100010, 6'b100100, 6'b100101,
                                         6'b100111, 6'b101010, 6'b000011, 6'b100100};
  localparam logic [3:0] DEC_EXP [12] = '{4'b0010, 4'b0110, 4'b0001, 4'b0010, 4'b0010, 4'b0110,
                                          4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0010, 4'b0010};

  task automatic test_back_to_back_decode();
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_instr(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, DEC_OP[i], DEC_FN[i], 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || alu_control !== DEC_EXP[i]) begin
        tests_failed++;
        $display("FAIL decode_%0d got v=%b ctrl=%b want 1/%b", i, out_valid, alu_control, DEC_EXP[i]);
      end
    end
    drain();
  endtask

  task automatic test_immediate();
    set_instr(5'd1, 5'd2, 5'd9, 32'd3, 32'd9, 32'hFFFF_FFFC, 2'b00, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++; if (b_opnd !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL imm_B got %h want fffffffc", b_opnd); end
    tests_run++; if (out_store_data !== 32'd9) begin tests_failed++; $display("FAIL imm_store got %h want 9", out_store_data); end
    tests_run++; if (out_mem_write !== 1'b1) begin tests_failed++; $display("FAIL imm_memwrite got %b want 1", out_mem_write); end
    drain();
  endtask

  task automatic test_forwarding();
    clear_wb();
    set_instr(5'd4, 5'd2, 5'd8, 32'h99, 32'h77, 32'd0, 2'b10, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h10;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h20;
    #1;
`ifdef ID_EX_FORWARDING_EN
    tests_run++; if (a_opnd !== 32'h10) begin tests_failed++; $display("FAIL fwd_exmem got %h want 10", a_opnd); end
`else
    tests_run++; if (a_opnd !== 32'h99) begin tests_failed++; $display("FAIL nofwd_exmem got %h want 99", a_opnd); end
`endif
    exmem_reg_write = 1'b0;
    #1;
`ifdef ID_EX_FORWARDING_EN
    tests_run++; if (a_opnd !== 32'h20) begin tests_failed++; $display("FAIL fwd_memwb got %h want 20", a_opnd); end
`else
    tests_run++; if (a_opnd !== 32'h99) begin tests_failed++; $display("FAIL nofwd_memwb got %h want 99", a_opnd); end
`endif
    tests_run++; if (b_opnd !== 32'h77) begin tests_failed++; $display("FAIL fwd_B_nomatch got %h want 77", b_opnd); end
    clear_wb();
    tick();
    set_instr(5'd0, 5'd2, 5'd8, 32'h33, 32'h77, 32'd0, 2'b10, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h55;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h66;
    #1;
    tests_run++; if (a_opnd !== 32'h33) begin tests_failed++; $display("FAIL fwd_reg0 got %h want 33", a_opnd); end
    clear_wb();
    drain();
  endtask

  task automatic load_lw5();
    set_instr(5'd1, 5'd5, 5'd5, 32'h100, 32'd0, 32'd4, 2'b00, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    clear_wb();
    load_lw5();
    set_instr(5'd5, 5'd1, 5'd6, 32'h1, 32'h2, 32'd0, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL lu_stall got in_ready=%b want 0", in_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lu_bubble got out_valid=%b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL lu_release got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1 || alu_control !== 4'b0110 || out_rd !== 5'd6) begin tests_failed++; $display("FAIL lu_sub got v=%b ctrl=%b rd=%0d want 1/0110/6", out_valid, alu_control, out_rd); end
    drain();
    // an immediate-form consumer does not read rt, so rt matching the load is harmless
    load_lw5();
    set_instr(5'd1, 5'd5, 5'd7, 32'h1, 32'h2, 32'd8, 2'b00, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL lu_rt_unused got in_ready=%b want 1", in_ready); end
    drain();
    drain();
    // load into register 0 never stalls
    set_instr(5'd1, 5'd0, 5'd0, 32'h100, 32'd0, 32'd4, 2'b00, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1;
    tick();
    set_instr(5'd0, 5'd0, 5'd6, 32'h1, 32'h2, 32'd0, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL lu_reg0 got in_ready=%b want 1", in_ready); end
    drain();
    drain();
  endtask

  task automatic test_flush();
    clear_wb();
    load_lw5();
    set_instr(5'd5, 5'd1, 5'd6, 32'h1, 32'h2, 32'd0, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    tests_run++; if ({out_reg_write, out_mem_read, out_mem_write} !== 3'b000) begin tests_failed++; $display("FAIL flush_ctrl got %b want 000", {out_reg_write, out_mem_read, out_mem_write}); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    clear_wb();
    load_lw5();
    set_instr(5'd5, 5'd1, 5'd6, 32'h1, 32'h2, 32'd0, 2'b10, 6'b100010, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || out_mem_read !== 1'b0) begin tests_failed++; $display("FAIL rst_stall got v=%b mr=%b want 0/0", out_valid, out_mem_read); end
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_replay got v=%b want 0", out_valid); end
  endtask

  task automatic test_writer_dependency();
    clear_wb();
    set_instr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    set_instr(5'd3, 5'd3, 5'd7, 32'd4, 32'd4, 32'd0, 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef ID_EX_FORWARDING_EN
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL dep_fwd_no_stall got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin tests_failed++; $display("FAIL dep_fwd_load got v=%b rd=%0d want 1/7", out_valid, out_rd); end
`else
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL dep_held_stall got in_ready=%b want 0", in_ready); end
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'd3;
    #1;
    tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL dep_exmem_stall got rdy=%b v=%b want 0/0", in_ready, out_valid); end
    tick();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'd3;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL dep_release got in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin tests_failed++; $display("FAIL dep_load got v=%b rd=%0d want 1/7", out_valid, out_rd); end
`endif
    clear_wb();
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back_decode();
    test_immediate();
    test_forwarding();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    test_writer_dependency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
